muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (even, >=4).
REQ-002 SHALL have parameter CNTW, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1, request to begin an operation.
REQ-006 SHALL have port MDOp, input, 3, operation code: 000 MUL, 001 UMULL, 010 SMULL, 011 UDIV, 100 SDIV; 101-111 reserved.
REQ-007 SHALL have port SrcA, input, WIDTH, multiplicand or dividend.
REQ-008 SHALL have port SrcB, input, WIDTH, multiplier or divisor.
REQ-009 SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port ResultLo, output, WIDTH, product low half or quotient.
REQ-012 SHALL have port ResultHi, output, WIDTH, product high half or remainder.
REQ-013 SHALL have port Long, output, 1, high when the last result is a 2*WIDTH product.
REQ-014 SHALL have port Flags, output, 2, {N,Z} of the last result.
REQ-015 SHALL have port DivZero, output, 1, high when the last divide had SrcB==0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FIN.
REQ-017 IDLE: Start=1 with a valid MDOp SHALL latch MDOp, SrcA and SrcB, clear the counter, and go to RUN.
REQ-018 IDLE: Start=1 with a reserved MDOp SHALL be ignored; the FSM stays in IDLE.
REQ-019 RUN SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes, for exactly WIDTH cycles, then go to FIN.
REQ-020 SMULL and SDIV SHALL use two's-complement absolute values; sign is applied in FIN (product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA).
REQ-021 FIN SHALL register ResultLo, ResultHi, Flags, Long and DivZero, assert Done for exactly one cycle, and return to IDLE.
REQ-022 Latency: if Start is sampled at edge k, Done SHALL be high in the cycle after edge k+WIDTH+1; back-to-back Start is accepted the cycle after Done.
REQ-023 Busy SHALL be high in every cycle while the FSM is in RUN or FIN, including the Done cycle.
REQ-024 Start while Busy SHALL be ignored, with no effect on the operation in flight.
REQ-025 MUL SHALL return the low WIDTH bits in ResultLo, set ResultHi=0 and Long=0; Flags SHALL be computed on ResultLo.
REQ-026 UMULL and SMULL SHALL set Long=1; Flags SHALL be computed on {ResultHi,ResultLo} (N = bit 2*WIDTH-1, Z = all 64/2*WIDTH bits zero).
REQ-027 Divide SHALL set Long=0; Flags SHALL be computed on the quotient.
REQ-028 Divide by zero SHALL give quotient all ones, remainder = SrcA, DivZero=1; it SHALL take the normal latency.
REQ-029 SDIV of the most negative value by -1 SHALL give quotient = most negative value and remainder = 0.
REQ-030 Outputs SHALL hold their values from Done until the next FIN.

Reset
REQ-031 On reset the FSM SHALL go to IDLE, with Busy=0, Done=0, ResultLo=0, ResultHi=0, Long=0, Flags=00, DivZero=0 and the counter at 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation; no Done SHALL be produced for it.
REQ-033 Reset SHALL take priority over Start in the same cycle.

Verification
REQ-034 WIDTH=32, MUL 0x0001_0000 * 0x0001_0000 -> Done 34 cycles after Start; ResultLo=0, ResultHi=0, Flags=01, Long=0.
REQ-035 SMULL 0xFFFF_FFFF (-1) * 0x0000_0002 -> {Hi,Lo}=0xFFFF_FFFF_FFFF_FFFE, Flags=10, Long=1.
REQ-036 UDIV 100 / 7 -> ResultLo=14, ResultHi=2, DivZero=0; then SDIV -7 / 2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF.
REQ-037 UDIV 5 / 0 -> ResultLo=0xFFFF_FFFF, ResultHi=5, DivZero=1, Flags=10.
REQ-038 SDIV 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0.
REQ-039 Pulse Start during RUN, then assert reset at RUN cycle 10 -> Start ignored, no Done pulse, all outputs 0, next Start completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that processes one operand bit per clock.
//
// Operations (MDOp):
//   000 MUL    low half of the product
//   001 UMULL  unsigned 2*WIDTH product
//   010 SMULL  signed 2*WIDTH product
//   011 UDIV   unsigned quotient/remainder
//   100 SDIV   signed quotient/remainder
//   101-111    reserved; a Start with one of these codes is ignored.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   Start, MDOp         request and operation code, sampled while idle
//   SrcA, SrcB          multiplicand/multiplier, or dividend/divisor
//   Busy                high from acceptance through the Done cycle
//   Done                one-cycle completion pulse
//   ResultLo, ResultHi  product low/high half, or quotient/remainder
//   Long                the last result is a 2*WIDTH product
//   Flags               {N,Z} of the last result
//   DivZero             the last divide had a zero divisor
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Long,
  output logic [1:0]       Flags,
  output logic             DivZero
);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b001;
  localparam logic [2:0] OP_SMULL = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b011;
  localparam logic [2:0] OP_SDIV  = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] a_raw;           // original dividend, returned as remainder on divide-by-zero
  logic [WIDTH-1:0] b_mag;           // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi, acc_lo;  // product halves, or remainder/quotient
  logic [CNTW-1:0]  cnt;

  // Input decode used only on the accepting cycle
  logic             op_valid, signed_in, start_ok;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign op_valid  = (MDOp <= OP_SDIV);
  assign signed_in = (MDOp == OP_SMULL) || (MDOp == OP_SDIV);
  assign a_mag_in  = (signed_in && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign b_mag_in  = (signed_in && SrcB[WIDTH-1]) ? -SrcB : SrcB;
  // The Done cycle is already back in IDLE but still counts as busy, so a
  // new request is only taken the cycle after the Done pulse.
  assign start_ok  = (state == IDLE) && Start && op_valid && !Done;

  assign Busy = (state != IDLE) || Done;

  // ---------------------------------------------------------------- FSM
  // NOTE: state-holding processes use non-blocking (<=) so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (cnt == CNTW'(WIDTH - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------ one RUN step
  logic             is_div;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign is_div = (op_q == OP_UDIV) || (op_q == OP_SDIV);

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole {hi,lo} pair right by one.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // --------------------------------------------- sign fix-up and flags
  logic [2*WIDTH-1:0] prod_mag, prod_sgn;
  logic [WIDTH-1:0]   quo, rem, fin_lo, fin_hi;
  logic               fin_long, fin_dz;
  logic [1:0]         fin_flags;

  always_comb begin
    prod_mag  = {acc_hi, acc_lo};
    prod_sgn  = (op_q == OP_SMULL && (sign_a ^ sign_b)) ? -prod_mag : prod_mag;
    quo       = (op_q == OP_SDIV && (sign_a ^ sign_b)) ? -acc_lo : acc_lo;
    rem       = (op_q == OP_SDIV && sign_a) ? -acc_hi : acc_hi;
    fin_lo    = acc_lo;
    fin_hi    = '0;
    fin_long  = 1'b0;
    fin_dz    = 1'b0;
    fin_flags = {fin_lo[WIDTH-1], (fin_lo == '0)};
    case (op_q)
      OP_MUL: ;
      OP_UMULL, OP_SMULL: begin
        {fin_hi, fin_lo} = prod_sgn;
        fin_long  = 1'b1;
        fin_flags = {prod_sgn[2*WIDTH-1], (prod_sgn == '0)};
      end
      default: begin
        // A zero divisor magnitude only arises from SrcB == 0.
        if (b_mag == '0) begin
          fin_lo = '1;
          fin_hi = a_raw;
          fin_dz = 1'b1;
        end else begin
          fin_lo = quo;
          fin_hi = rem;
        end
        fin_flags = {fin_lo[WIDTH-1], (fin_lo == '0)};
      end
    endcase
  end

  // ------------------------------------------------ datapath registers
  // NOTE: the internal datapath registers are reset along with the outputs;
  // this is a handful of flops, not a memory array, so it costs nothing
  // meaningful and keeps simulation free of X after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MUL;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      a_raw    <= '0;
      b_mag    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      Done     <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
      Long     <= 1'b0;
      Flags    <= 2'b00;
      DivZero  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (start_ok) begin
          op_q   <= MDOp;
          sign_a <= signed_in & SrcA[WIDTH-1];
          sign_b <= signed_in & SrcB[WIDTH-1];
          a_raw  <= SrcA;
          b_mag  <= b_mag_in;
          acc_hi <= '0;
          acc_lo <= a_mag_in;
          cnt    <= '0;
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNTW'(1);
        end
        FIN: begin
          ResultLo <= fin_lo;
          ResultHi <= fin_hi;
          Long     <= fin_long;
          Flags    <= fin_flags;
          DivZero  <= fin_dz;
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32).
// A transaction-level model predicts Busy/Done and the registered results;
// a compare process checks the DUT against it on every falling edge.
// Directed operations pin the model and DUT to hand-computed values.
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MUL = 3'd0, OP_UMULL = 3'd1, OP_SMULL = 3'd2,
                         OP_UDIV = 3'd3, OP_SDIV = 3'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic [2:0]    MDOp = 3'd0;
  logic [W-1:0]  SrcA = '0, SrcB = '0;
  logic          Busy, Done, Long, DivZero;
  logic [W-1:0]  ResultLo, ResultHi;
  logic [1:0]    Flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .Long(Long),
    .Flags(Flags), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Arithmetic reference: results straight from integer arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] lo, output logic [W-1:0] hi,
                                    output logic lng, output logic [1:0] fl, output logic dz);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    lo = '0; hi = '0; lng = 1'b0; dz = 1'b0;
    case (op)
      OP_MUL:   begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; end
      OP_UMULL: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; lng = 1'b1; end
      OP_SMULL: begin p = sa * sb; {hi, lo} = p; lng = 1'b1; end
      default: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (op == OP_UDIV) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
    if (lng) fl = {hi[W-1], ({hi, lo} == 64'd0)};
    else     fl = {lo[W-1], (lo == '0)};
  endfunction

  // Transaction-level timing model: an accepted request completes WIDTH+1
  // edges later; the unit is busy until the Done cycle has passed.
  logic         m_en = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  int           m_left = 0;
  logic [W-1:0] e_lo = '0, e_hi = '0, p_lo, p_hi;
  logic         e_long = 1'b0, e_dz = 1'b0, p_long, p_dz;
  logic [1:0]   e_fl = 2'b00, p_fl;

  initial forever begin
    logic prev_done;
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_en = 1'b1; m_left = 0; m_done = 1'b0;
      e_lo = '0; e_hi = '0; e_long = 1'b0; e_fl = 2'b00; e_dz = 1'b0;
    end else begin
      prev_done = m_done;
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          e_lo = p_lo; e_hi = p_hi; e_long = p_long; e_fl = p_fl; e_dz = p_dz;
        end
      end else if (!prev_done && Start && MDOp <= OP_SDIV) begin
        m_left = W + 1;
        ref_model(MDOp, SrcA, SrcB, p_lo, p_hi, p_long, p_fl, p_dz);
      end
    end
    m_busy = (m_left != 0) || m_done;
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (m_en) begin
      check("busy", Busy, m_busy);
      check("done", Done, m_done);
      check("result_lo", ResultLo, e_lo);
      check("result_hi", ResultHi, e_hi);
      check("long", Long, e_long);
      check("flags", Flags, e_fl);
      check("divzero", DivZero, e_dz);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    int c0;
    @(negedge clk);
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b; c0 = cyc;
    @(negedge clk);
    Start = 1'b0; SrcA = $urandom(); SrcB = $urandom();
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (Done) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout op=%0d: actual=no Done required=Done within 100 cycles", op);
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #400us;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           lat, seen;
    logic [W-1:0] mlo, mhi;
    logic         mlong, mdz;
    logic [1:0]   mfl;

    // Model pins against hand-computed values
    ref_model(OP_SDIV, 32'hFFFF_FFF9, 32'd2, mlo, mhi, mlong, mfl, mdz);
    check("model_sdiv_q", mlo, 32'hFFFF_FFFD);
    check("model_sdiv_r", mhi, 32'hFFFF_FFFF);
    ref_model(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mlo, mhi, mlong, mfl, mdz);
    check("model_umull", {mhi, mlo}, 64'hFFFF_FFFE_0000_0001);

    repeat (3) @(negedge clk);
    check("reset_busy", Busy, 1'b0);
    check("reset_lo", ResultLo, '0);
    reset = 1'b0;

    // Directed operations with literal expectations
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat);
    check("mul_latency", lat, 34);
    check("mul_lo", ResultLo, 32'h0);
    check("mul_hi", ResultHi, 32'h0);
    check("mul_flags", Flags, 2'b01);
    check("mul_long", Long, 1'b0);

    run_op(OP_SMULL, 32'hFFFF_FFFF, 32'h2, lat);
    check("smull_prod", {ResultHi, ResultLo}, 64'hFFFF_FFFF_FFFF_FFFE);
    check("smull_flags", Flags, 2'b10);
    check("smull_long", Long, 1'b1);

    run_op(OP_UDIV, 32'd100, 32'd7, lat);
    check("udiv_q", ResultLo, 32'd14);
    check("udiv_r", ResultHi, 32'd2);
    check("udiv_dz", DivZero, 1'b0);

    run_op(OP_SDIV, 32'hFFFF_FFF9, 32'd2, lat);
    check("sdiv_q", ResultLo, 32'hFFFF_FFFD);
    check("sdiv_r", ResultHi, 32'hFFFF_FFFF);

    run_op(OP_UDIV, 32'd5, 32'd0, lat);
    check("div0_latency", lat, 34);
    check("div0_q", ResultLo, 32'hFFFF_FFFF);
    check("div0_r", ResultHi, 32'd5);
    check("div0_dz", DivZero, 1'b1);
    check("div0_flags", Flags, 2'b10);

    run_op(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("sdiv_min_q", ResultLo, 32'h8000_0000);
    check("sdiv_min_r", ResultHi, 32'h0);

    // Reserved opcode is ignored
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd6; SrcA = 32'd3; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    check("reserved_busy", Busy, 1'b0);

    // Start during RUN, then reset partway through: no Done, outputs cleared
    @(negedge clk);
    Start = 1'b1; MDOp = OP_UMULL; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    Start = 1'b1; MDOp = OP_UDIV; SrcA = 32'd50; SrcB = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", Busy, 1'b0);
    check("abort_lo", ResultLo, '0);
    check("abort_hi", ResultHi, '0);
    check("abort_flags", Flags, 2'b00);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("after_abort_latency", lat, 34);
    check("after_abort_prod", {ResultHi, ResultLo}, 64'hFFFF_FFFE_0000_0001);

    // Randomized traffic, including reserved codes, Start while busy and rare resets
    for (int i = 0; i < 2500; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 11);
      Start = ($urandom_range(0, 2) == 0);
      MDOp  = (r < 10) ? 3'(r % 5) : 3'(5 + r % 3);
      SrcA  = rnd_operand();
      SrcB  = rnd_operand();
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    Start = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
